dmem_bus_bridge: RTL and testbench

Sits directly downstream of the load/store byte-lane handler, on its word-aligned data-memory port, and converts it to a multi-cycle request/acknowledge memory bus. It holds each access stable on the bus until the slave acknowledges, errors, or times out, and stalls the pipeline for the duration. It returns a registered read word, which the upstream handler sign- or zero-extends.

---
 rtl/mem_bus_pkg.sv | 28 ++
 rtl/bus_timeout_counter.sv | 47 ++++
 rtl/dmem_bus_bridge.sv | 118 +++++++++++
 tb/tb_dmem_bus_bridge.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the data-memory request/acknowledge bridge.
//   bus_state_t    : bridge FSM states
//   bus_payload_t  : address/strobe/data held on the bus for one access
//   WSTRB_READ     : strobe pattern that marks a read
//   ADDR_ALIGN_MASK: clears the byte offset to form a word address
package mem_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned CNT_W  = 16;

    localparam logic [ADDR_W-1:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [STRB_W-1:0] WSTRB_READ      = 4'b0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } bus_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] wdata;
    } bus_payload_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts cycles spent waiting on the bus. expired_o is registered and is high
// in the cycle in which the count equals LIMIT-1.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : restart the count at 0
//   en_i       : advance the count by one
//   expired_o  : count has reached LIMIT-1
module bus_timeout_counter
    import mem_bus_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_q, expired_d;

    // Next count; expired tracks the next count so it lines up with cnt_q.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        expired_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/dmem_bus_bridge.sv
// Converts the word-aligned data-memory port into a request/acknowledge bus.
// One access at a time; the pipeline is stalled until the access completes.
//   req_valid/addr/wdata/wstrb : access from the byte-lane handler
//   rdata, fault               : registered result, valid in DONE
//   stall                      : combinational pipeline hold
//   bus_*                      : registered bus request, slave response
module dmem_bus_bridge
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              fault,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [STRB_W-1:0] bus_wstrb,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_err
);

    bus_state_t        state_q, state_d;
    bus_payload_t      bus_q, bus_d;
    logic              bus_req_q, bus_req_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              fault_q, fault_d;
    logic              cnt_clr, cnt_en, cnt_expired;

    bus_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .expired_o(cnt_expired)
    );

    // Next-state and output decode; fault defaults low so it pulses once.
    always_comb begin
        state_d   = state_q;
        bus_d     = bus_q;
        bus_req_d = bus_req_q;
        rdata_d   = rdata_q;
        fault_d   = 1'b0;
        stall     = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    bus_d.addr  = addr & ADDR_ALIGN_MASK;
                    bus_d.wstrb = wstrb;
                    bus_d.wdata = wdata;
                    bus_req_d   = 1'b1;
                    cnt_clr     = 1'b1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                stall  = 1'b1;
                cnt_en = 1'b1;
                // Error beats ack; timeout only when the slave stays silent.
                if (bus_err || (!bus_ack && cnt_expired)) begin
                    fault_d   = 1'b1;
                    rdata_d   = '0;
                    bus_req_d = 1'b0;
                    state_d   = DONE;
                end else if (bus_ack) begin
                    rdata_d   = (bus_q.wstrb == WSTRB_READ) ? bus_rdata : '0;
                    bus_req_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                // req_valid here still belongs to the finished access.
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bus_q     <= '0;
            bus_req_q <= 1'b0;
            rdata_q   <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_q     <= bus_d;
            bus_req_q <= bus_req_d;
            rdata_q   <= rdata_d;
            fault_q   <= fault_d;
        end
    end

    assign rdata     = rdata_q;
    assign fault     = fault_q;
    assign bus_req   = bus_req_q;
    assign bus_addr  = bus_q.addr;
    assign bus_wstrb = bus_q.wstrb;
    assign bus_wdata = bus_q.wdata;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge with TIMEOUT_CYCLES = 4.
module tb_dmem_bus_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        stall;
    logic        fault;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int n_pass  = 0;
    int n_total = 0;
    int n_txn   = 0;
    int txn_base;
    logic req_prev = 1'b0;

    always #5 clk = ~clk;

    dmem_bus_bridge #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .addr     (addr),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .rdata    (rdata),
        .stall    (stall),
        .fault    (fault),
        .bus_req  (bus_req),
        .bus_addr (bus_addr),
        .bus_wstrb(bus_wstrb),
        .bus_wdata(bus_wdata),
        .bus_ack  (bus_ack),
        .bus_rdata(bus_rdata),
        .bus_err  (bus_err)
    );

    // Count bus transactions as rising edges of bus_req.
    always @(posedge clk) begin
        req_prev <= bus_req;
        if (bus_req && !req_prev) n_txn <= n_txn + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
        #3;
        chk("rst_bus_req",   32'(bus_req),   32'd0);
        chk("rst_bus_addr",  bus_addr,       32'd0);
        chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        chk("rst_bus_wdata", bus_wdata,      32'd0);
        chk("rst_rdata",     rdata,          32'd0);
        chk("rst_fault",     32'(fault),     32'd0);
        chk("rst_stall",     32'(stall),     32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Read, ack on BUSY cycle 2
        req_valid = 1'b1; addr = 32'h0000_1003; wstrb = 4'b0000; wdata = '0; #1;
        chk("rd_c0_stall",   32'(stall),   32'd1);
        chk("rd_c0_bus_req", 32'(bus_req), 32'd0);
        tick();
        chk("rd_c1_bus_req", 32'(bus_req), 32'd1);
        chk("rd_c1_addr",    bus_addr,     32'h0000_1000);
        chk("rd_c1_stall",   32'(stall),   32'd1);
        addr = 32'hFFFF_FFFF;
        tick();
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF; #1;
        chk("rd_c2_bus_req", 32'(bus_req), 32'd1);
        chk("rd_c2_addr",    bus_addr,     32'h0000_1000);
        chk("rd_c2_stall",   32'(stall),   32'd1);
        tick();
        bus_ack = 1'b0;
        chk("rd_done_bus_req", 32'(bus_req), 32'd0);
        chk("rd_done_stall",   32'(stall),   32'd0);
        chk("rd_done_rdata",   rdata,        32'hDEAD_BEEF);
        chk("rd_done_fault",   32'(fault),   32'd0);
        req_valid = 1'b0;
        tick();
        chk("rd_idle_bus_req", 32'(bus_req), 32'd0);
        chk("rd_idle_stall",   32'(stall),   32'd0);

        // Byte store, immediate ack
        req_valid = 1'b1; addr = 32'h0000_2000; wstrb = 4'b0100; wdata = 32'h5A5A_5A5A; #1;
        chk("st_c0_stall", 32'(stall), 32'd1);
        tick();
        chk("st_c1_wstrb",   32'(bus_wstrb), 32'h4);
        chk("st_c1_wdata",   bus_wdata,      32'h5A5A_5A5A);
        chk("st_c1_bus_req", 32'(bus_req),   32'd1);
        chk("st_c1_stall",   32'(stall),     32'd1);
        wstrb = 4'hF; wdata = '0; bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        tick();
        bus_ack = 1'b0;
        chk("st_done_rdata", rdata,          32'd0);
        chk("st_done_wstrb", 32'(bus_wstrb), 32'h4);
        chk("st_done_stall", 32'(stall),     32'd0);
        chk("st_done_fault", 32'(fault),     32'd0);
        req_valid = 1'b0; wstrb = 4'b0000;
        tick();

        // Error and ack together on BUSY cycle 1
        req_valid = 1'b1; addr = 32'h0000_3000;
        tick();
        bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'hCAFE_F00D;
        tick();
        bus_ack = 1'b0; bus_err = 1'b0;
        chk("err_done_fault",   32'(fault),   32'd1);
        chk("err_done_rdata",   rdata,        32'd0);
        chk("err_done_bus_req", 32'(bus_req), 32'd0);
        req_valid = 1'b0;
        tick();
        chk("err_idle_fault",   32'(fault),   32'd0);
        chk("err_idle_stall",   32'(stall),   32'd0);
        chk("err_idle_bus_req", 32'(bus_req), 32'd0);

        // Timeout after 4 BUSY cycles
        req_valid = 1'b1; addr = 32'h0000_4000;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("to_c%0d_bus_req", k), 32'(bus_req), 32'd1);
        end
        tick();
        chk("to_done_bus_req", 32'(bus_req), 32'd0);
        chk("to_done_fault",   32'(fault),   32'd1);
        chk("to_done_rdata",   rdata,        32'd0);
        chk("to_done_stall",   32'(stall),   32'd0);
        req_valid = 1'b0;
        tick();
        bus_ack = 1'b1; bus_rdata = 32'hAAAA_5555;
        tick();
        bus_ack = 1'b0;
        chk("stray_bus_req", 32'(bus_req), 32'd0);
        chk("stray_rdata",   rdata,        32'd0);
        chk("stray_fault",   32'(fault),   32'd0);
        chk("stray_stall",   32'(stall),   32'd0);

        // Back-to-back loads, req_valid held across DONE
        txn_base = n_txn;
        req_valid = 1'b1; addr = 32'h0000_0100;
        tick();
        bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
        tick();
        bus_ack = 1'b0;
        chk("b2b_done1_bus_req", 32'(bus_req), 32'd0);
        chk("b2b_done1_rdata",   rdata,        32'h1111_1111);
        addr = 32'h0000_0204;
        tick();
        chk("b2b_idle_bus_req", 32'(bus_req), 32'd0);
        chk("b2b_idle_stall",   32'(stall),   32'd1);
        tick();
        chk("b2b_busy2_bus_req", 32'(bus_req), 32'd1);
        chk("b2b_busy2_addr",    bus_addr,     32'h0000_0204);
        bus_ack = 1'b1; bus_rdata = 32'h2222_2222;
        tick();
        bus_ack = 1'b0;
        chk("b2b_done2_rdata", rdata, 32'h2222_2222);
        req_valid = 1'b0;
        tick();
        chk("b2b_idle2_bus_req", 32'(bus_req), 32'd0);
        tick();
        chk("b2b_txn_count", 32'(n_txn - txn_base), 32'd2);

        // Reset during BUSY
        req_valid = 1'b1; addr = 32'h0000_5000; wstrb = 4'b0010; wdata = 32'h0000_0077;
        tick();
        chk("rb_busy_bus_req", 32'(bus_req), 32'd1);
        #2;
        rst_n = 1'b0; req_valid = 1'b0;
        #1;
        chk("rb_async_bus_req", 32'(bus_req),   32'd0);
        chk("rb_bus_addr",      bus_addr,       32'd0);
        chk("rb_bus_wstrb",     32'(bus_wstrb), 32'd0);
        chk("rb_bus_wdata",     bus_wdata,      32'd0);
        chk("rb_rdata",         rdata,          32'd0);
        chk("rb_fault",         32'(fault),     32'd0);
        chk("rb_stall",         32'(stall),     32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("rb_after_fault",   32'(fault),   32'd0);
        chk("rb_after_bus_req", 32'(bus_req), 32'd0);
        chk("rb_after_stall",   32'(stall),   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
